// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32 datapath (lw, sw, add/sub/and/or, addi/andi/ori, beq).
// Outputs decode from the state register; pc_write also follows the ALU zero flag in BRANCH.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic             zero,
    output logic             pc_write,
    output logic             IorD,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             pc_source,
    output logic [3:0]       alu_control,
    output logic             halted,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_retired
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_R_WB     = 4'd7,
        S_EXEC_I   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_HALT     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    state_t           r_state;
    logic [CNT_W-1:0] r_retired;

    logic       w_r_ok;
    logic [3:0] w_r_alu;
    logic       w_i_ok;
    logic [3:0] w_i_alu;
    logic       w_beq_ok;

    always_comb begin
        w_r_ok  = 1'b1;
        w_r_alu = ALU_ADD;
        case ({funct7_5, funct3})
            4'b0000: w_r_alu = ALU_ADD;
            4'b1000: w_r_alu = ALU_SUB;
            4'b0111: w_r_alu = ALU_AND;
            4'b0110: w_r_alu = ALU_OR;
            default: w_r_ok  = 1'b0;
        endcase

        w_i_ok  = 1'b1;
        w_i_alu = ALU_ADD;
        case (funct3)
            3'b000:  w_i_alu = ALU_ADD;
            3'b111:  w_i_alu = ALU_AND;
            3'b110:  w_i_alu = ALU_OR;
            default: w_i_ok  = 1'b0;
        endcase

        w_beq_ok = (funct3 == 3'b000);
    end

    // Unsupported funct encodings leave for HALT without reaching write-back or retiring.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_retired <= '0;
        end else begin
            case (r_state)
                S_FETCH:  r_state <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: r_state <= S_MEM_ADDR;
                        OP_R:         r_state <= S_EXEC_R;
                        OP_I:         r_state <= S_EXEC_I;
                        OP_BEQ:       r_state <= S_BRANCH;
                        default:      r_state <= S_HALT;
                    endcase
                end
                S_MEM_ADDR: r_state <= (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:   r_state <= S_MEM_WB;
                S_EXEC_R:   r_state <= w_r_ok ? S_R_WB : S_HALT;
                S_EXEC_I:   r_state <= w_i_ok ? S_I_WB : S_HALT;
                S_MEM_WB, S_MEM_WR, S_R_WB, S_I_WB: begin
                    r_state   <= S_FETCH;
                    r_retired <= r_retired + CNT_W'(1);
                end
                S_BRANCH: begin
                    if (w_beq_ok) begin
                        r_state   <= S_FETCH;
                        r_retired <= r_retired + CNT_W'(1);
                    end else begin
                        r_state <= S_HALT;
                    end
                end
                default: r_state <= S_HALT;
            endcase
        end
    end

    always_comb begin
        pc_write    = 1'b0;
        IorD        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        pc_source   = 1'b0;
        alu_control = ALU_ADD;
        halted      = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                alu_src_b = 2'b01;
            end
            S_DECODE: begin
                pc_write  = 1'b1;
                pc_source = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                IorD     = 1'b1;
                mem_read = 1'b1;
            end
            S_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEM_WR: begin
                IorD      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a   = 1'b1;
                alu_control = w_r_alu;
            end
            S_EXEC_I: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = w_i_alu;
            end
            S_R_WB, S_I_WB: reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                pc_source   = 1'b1;
                pc_write    = zero & w_beq_ok;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase

        if (reset) begin
            pc_write  = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
        end
    end

    assign state         = r_state;
    assign instr_retired = r_retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: stimulus pushes per-cycle expectations, a negedge monitor
// pops and compares state, control bundle and retired count.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  opcode = 7'd0;
    logic [2:0]  funct3 = 3'd0;
    logic        funct7_5 = 1'b0;
    logic        zero = 1'b0;
    logic        pc_write, IorD, mem_read, mem_write, ir_write, mem_to_reg, reg_write;
    logic        alu_src_a, pc_source, halted;
    logic [1:0]  alu_src_b;
    logic [3:0]  alu_control, state;
    logic [31:0] instr_retired;

    multicycle_control #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5), .zero(zero),
        .pc_write(pc_write), .IorD(IorD), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_source(pc_source), .alu_control(alu_control), .halted(halted),
        .state(state), .instr_retired(instr_retired)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [3:0] AND_ = 4'b0000, OR_ = 4'b0001, ADD_ = 4'b0010, SUB_ = 4'b0110;

    typedef struct {
        string       tag;
        logic [3:0]  st;
        logic [15:0] ctl;
        logic [31:0] ret;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_ret = 0;

    // Control bundle order: pc_write, IorD, mem_read, mem_write, ir_write, mem_to_reg, reg_write,
    // alu_src_a, alu_src_b[1:0], pc_source, alu_control[3:0], halted.
    function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic [3:0] alu,
                                              input logic pcw, input logic rst);
        logic pw, iod, mr, mw, irw, m2r, rw, asa, pcs, hl;
        logic [1:0] asb;
        logic [3:0] ac;
        {pw, iod, mr, mw, irw, m2r, rw, asa, pcs, hl} = '0;
        asb = 2'b00;
        ac  = ADD_;
        case (st)
            4'd0:  begin mr = 1; irw = 1; asb = 2'b01; end
            4'd1:  begin pw = 1; pcs = 1; asb = 2'b10; end
            4'd2:  begin asa = 1; asb = 2'b10; end
            4'd3:  begin iod = 1; mr = 1; end
            4'd4:  begin m2r = 1; rw = 1; end
            4'd5:  begin iod = 1; mw = 1; end
            4'd6:  begin asa = 1; ac = alu; end
            4'd7:  rw = 1;
            4'd8:  begin asa = 1; asb = 2'b10; ac = alu; end
            4'd9:  rw = 1;
            4'd10: begin asa = 1; ac = SUB_; pcs = 1; pw = pcw; end
            4'd15: hl = 1;
            default: ;
        endcase
        if (rst) {pw, mr, mw, irw, rw} = '0;
        return {pw, iod, mr, mw, irw, m2r, rw, asa, asb, pcs, ac, hl};
    endfunction

    task automatic step(input string tag, input logic rst, input logic [6:0] op, input logic [2:0] f3,
                        input logic f75, input logic z, input logic [3:0] est, input logic [3:0] alu,
                        input logic pcw);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst; opcode = op; funct3 = f3; funct7_5 = f75; zero = z;
        e.tag = tag;
        e.st  = est;
        e.ctl = exp_ctrl(est, alu, pcw, rst);
        e.ret = exp_ret;
        q.push_back(e);
    endtask

    task automatic do_i(input string tag, input logic [2:0] f3, input logic [3:0] alu);
        step({tag, "_F"}, 0, OP_I, f3, 0, 0, 4'd0, ADD_, 0);
        step({tag, "_D"}, 0, OP_I, f3, 0, 0, 4'd1, ADD_, 0);
        step({tag, "_X"}, 0, OP_I, f3, 0, 0, 4'd8, alu, 0);
        step({tag, "_WB"}, 0, OP_I, f3, 0, 0, 4'd9, ADD_, 0);
        exp_ret++;
    endtask

    task automatic do_r(input string tag, input logic f75, input logic [2:0] f3, input logic [3:0] alu);
        step({tag, "_F"}, 0, OP_R, f3, f75, 0, 4'd0, ADD_, 0);
        step({tag, "_D"}, 0, OP_R, f3, f75, 0, 4'd1, ADD_, 0);
        step({tag, "_X"}, 0, OP_R, f3, f75, 0, 4'd6, alu, 0);
        step({tag, "_WB"}, 0, OP_R, f3, f75, 0, 4'd7, ADD_, 0);
        exp_ret++;
    endtask

    task automatic do_beq(input string tag, input logic z);
        step({tag, "_F"}, 0, OP_BEQ, 3'b000, 0, z, 4'd0, ADD_, 0);
        step({tag, "_D"}, 0, OP_BEQ, 3'b000, 0, z, 4'd1, ADD_, 0);
        step({tag, "_BR"}, 0, OP_BEQ, 3'b000, 0, z, 4'd10, SUB_, z);
        exp_ret++;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [15:0] act;
            e = q.pop_front();
            act = {pc_write, IorD, mem_read, mem_write, ir_write, mem_to_reg, reg_write,
                   alu_src_a, alu_src_b, pc_source, alu_control, halted};
            checks++;
            if (state !== e.st || act !== e.ctl || instr_retired !== e.ret) begin
                failures++;
                $display("FAIL %s: got state=%0d ctl=%h ret=%0d, expected state=%0d ctl=%h ret=%0d",
                         e.tag, state, act, instr_retired, e.st, e.ctl, e.ret);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step("reset", 1, OP_I, 3'b000, 0, 0, 4'd0, ADD_, 0);
        exp_ret = 0;

        do_i("addi", 3'b000, ADD_);

        step("lw_F", 0, OP_LW, 3'b010, 0, 0, 4'd0, ADD_, 0);
        step("lw_D", 0, OP_LW, 3'b010, 0, 0, 4'd1, ADD_, 0);
        step("lw_A", 0, OP_LW, 3'b010, 0, 0, 4'd2, ADD_, 0);
        step("lw_RD", 0, OP_LW, 3'b010, 0, 0, 4'd3, ADD_, 0);
        step("lw_WB", 0, OP_LW, 3'b010, 0, 0, 4'd4, ADD_, 0);
        exp_ret++;

        step("sw_F", 0, OP_SW, 3'b010, 0, 0, 4'd0, ADD_, 0);
        step("sw_D", 0, OP_SW, 3'b010, 0, 0, 4'd1, ADD_, 0);
        step("sw_A", 0, OP_SW, 3'b010, 0, 0, 4'd2, ADD_, 0);
        step("sw_WR", 0, OP_SW, 3'b010, 0, 0, 4'd5, ADD_, 0);
        exp_ret++;

        do_beq("beq_taken", 1);
        do_beq("beq_not", 0);
        do_r("sub", 1, 3'b000, SUB_);
        do_r("and", 0, 3'b111, AND_);
        do_i("ori", 3'b110, OR_);

        // beq with funct3 != 000: no PC write even with zero high, then HALT without retiring
        step("bne_F", 0, OP_BEQ, 3'b001, 0, 1, 4'd0, ADD_, 0);
        step("bne_D", 0, OP_BEQ, 3'b001, 0, 1, 4'd1, ADD_, 0);
        step("bne_BR", 0, OP_BEQ, 3'b001, 0, 1, 4'd10, SUB_, 0);
        repeat (3) step("bne_halt", 0, OP_BEQ, 3'b001, 0, 1, 4'd15, ADD_, 0);
        step("bne_rst", 1, OP_R, 3'b100, 0, 0, 4'd15, ADD_, 0);
        exp_ret = 0;

        step("rbad_F", 0, OP_R, 3'b100, 0, 0, 4'd0, ADD_, 0);
        step("rbad_D", 0, OP_R, 3'b100, 0, 0, 4'd1, ADD_, 0);
        step("rbad_X", 0, OP_R, 3'b100, 0, 0, 4'd6, ADD_, 0);
        repeat (4) step("rbad_halt", 0, OP_R, 3'b100, 0, 0, 4'd15, ADD_, 0);
        step("rbad_rst", 1, 7'h7F, 3'b000, 0, 0, 4'd15, ADD_, 0);
        exp_ret = 0;

        step("ill_F", 0, 7'h7F, 3'b000, 0, 0, 4'd0, ADD_, 0);
        step("ill_D", 0, 7'h7F, 3'b000, 0, 0, 4'd1, ADD_, 0);
        repeat (20) step("ill_halt", 0, 7'h7F, 3'b000, 0, 1, 4'd15, ADD_, 0);
        step("ill_rst", 1, OP_LW, 3'b010, 0, 0, 4'd15, ADD_, 0);
        exp_ret = 0;

        // Reset arriving in MEM_RD: mem_read is forced low and the FSM restarts at FETCH
        step("mid_F", 0, OP_LW, 3'b010, 0, 0, 4'd0, ADD_, 0);
        step("mid_D", 0, OP_LW, 3'b010, 0, 0, 4'd1, ADD_, 0);
        step("mid_A", 0, OP_LW, 3'b010, 0, 0, 4'd2, ADD_, 0);
        step("mid_RD_rst", 1, OP_LW, 3'b010, 0, 0, 4'd3, ADD_, 0);
        exp_ret = 0;
        do_i("andi", 3'b111, AND_);

        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (q.size() != 0) begin
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
            $fatal(1, "drain timeout");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
